// File: rtl/sme_pkg.sv
// Shared types, constants and helpers for the string-matching pattern scheduler.
package sme_pkg;

    localparam int PAT_ROM_AW = 7;
    localparam int PAT_NO_W   = 4;
    localparam int PAT_IDX_W  = 5;
    localparam int LEN_W      = 6;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h0A;
    localparam logic [7:0] END_CHAR_DEF  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRIME     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } sched_state_e;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        logic [7:0] r;
        if ((c >= 8'h41) && (c <= 8'h5A)) begin
            r = c + 8'h20;
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/sme_pat_buf.sv
// Pattern buffer: one synchronous write port, one combinational read port.
module sme_pat_buf
    import sme_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PAT_IDX_W-1:0] wr_idx,
    input  logic [7:0]           wr_data,
    input  logic [PAT_IDX_W-1:0] pat_idx,
    output logic [7:0]           pat_char
);

    logic [7:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; only loaded characters are ever read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign pat_char = mem_q[pat_idx];

endmodule

// File: rtl/sme_pattern_sched.sv
// Pattern scheduler: walks the pattern ROM, loads one pattern at a time into a
// local buffer and hands it to the text-scan matcher over a start/done handshake.
module sme_pattern_sched
    import sme_pkg::*;
#(
    parameter int         MAX_LEN   = 32,
    parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEF,
    parameter logic [7:0] END_CHAR  = END_CHAR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  case_insensitive,
    output logic [PAT_ROM_AW-1:0] P_addr,
    input  logic [7:0]            P_data,
    output logic                  mstart,
    output logic [LEN_W-1:0]      mpat_len,
    output logic [PAT_NO_W-1:0]   pattern_no,
    input  logic [PAT_IDX_W-1:0]  pat_idx,
    output logic [7:0]            pat_char,
    input  logic                  mdone,
    output logic                  busy,
    output logic                  finish,
    output logic                  len_ovf
);

    sched_state_e          state_q, state_d;
    logic [PAT_ROM_AW-1:0] addr_q, addr_d, step_addr_s;
    logic                  last_q, last_d, step_last_s;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [PAT_NO_W-1:0]   pat_no_q, pat_no_d;
    logic                  ovf_q, ovf_d;
    logic                  fold_q, fold_d;
    logic                  end_pend_q, end_pend_d;
    logic                  mstart_q, busy_q, finish_q;
    logic                  wr_en_s;
    logic [7:0]            wr_data_s;

    // Address advance saturates at the top; last_q marks that byte 127 is the one arriving
    always_comb begin
        if (addr_q == 7'h7F) begin
            step_addr_s = addr_q;
            step_last_s = 1'b1;
        end else begin
            step_addr_s = addr_q + 7'd1;
            step_last_s = 1'b0;
        end
    end

    assign wr_data_s = fold_q ? to_lower(P_data) : P_data;

    // Next-state logic; a held address after a terminator is the one-byte rewind
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        len_d      = len_q;
        pat_no_d   = pat_no_q;
        ovf_d      = ovf_q;
        fold_d     = fold_q;
        end_pend_d = end_pend_q;
        wr_en_s    = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (go) begin
                    state_d    = ST_PRIME;
                    addr_d     = 7'd0;
                    last_d     = 1'b0;
                    len_d      = 6'd0;
                    pat_no_d   = 4'd0;
                    ovf_d      = 1'b0;
                    fold_d     = case_insensitive;
                    end_pend_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PRIME: begin
                state_d = ST_LOAD;
                addr_d  = step_addr_s;
                last_d  = step_last_s;
            end
            ST_LOAD: begin
                if (P_data == END_CHAR) begin
                    state_d = ST_FINISH;
                end else if (P_data == TERM_CHAR) begin
                    if (len_q != 6'd0) begin
                        state_d    = ST_START;
                        end_pend_d = last_q;
                    end else if ((pat_no_q == 4'hF) || last_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        pat_no_d = pat_no_q + 4'd1;
                        addr_d   = step_addr_s;
                        last_d   = step_last_s;
                    end
                end else begin
                    if (len_q < LEN_W'(MAX_LEN)) begin
                        wr_en_s = 1'b1;
                        len_d   = len_q + 6'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (last_q) begin
                        state_d    = ST_START;
                        end_pend_d = 1'b1;
                    end else begin
                        addr_d = step_addr_s;
                        last_d = step_last_s;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mdone) begin
                    if ((pat_no_q == 4'hF) || end_pend_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d  = ST_PRIME;
                        pat_no_d = pat_no_q + 4'd1;
                        len_d    = 6'd0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; flags are decoded from the next state so they are registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 7'd0;
            last_q     <= 1'b0;
            len_q      <= 6'd0;
            pat_no_q   <= 4'd0;
            ovf_q      <= 1'b0;
            fold_q     <= 1'b0;
            end_pend_q <= 1'b0;
            mstart_q   <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            len_q      <= len_d;
            pat_no_q   <= pat_no_d;
            ovf_q      <= ovf_d;
            fold_q     <= fold_d;
            end_pend_q <= end_pend_d;
            mstart_q   <= (state_d == ST_START);
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_FINISH);
            finish_q   <= (state_d == ST_FINISH);
        end
    end

    sme_pat_buf #(
        .DEPTH (MAX_LEN)
    ) u_pat_buf (
        .clk      (clk),
        .wr_en    (wr_en_s),
        .wr_idx   (len_q[PAT_IDX_W-1:0]),
        .wr_data  (wr_data_s),
        .pat_idx  (pat_idx),
        .pat_char (pat_char)
    );

    assign P_addr     = addr_q;
    assign mstart     = mstart_q;
    assign mpat_len   = len_q;
    assign pattern_no = pat_no_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign len_ovf    = ovf_q;

endmodule

// File: tb/tb_sme_pattern_sched.sv
// Self-checking bench for sme_pattern_sched: ROM model, matcher model and table-walk reference model.
module tb_sme_pattern_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       case_insensitive;
    logic [6:0] P_addr;
    logic [7:0] P_data;
    logic       mstart;
    logic [5:0] mpat_len;
    logic [3:0] pattern_no;
    logic [4:0] pat_idx;
    logic [7:0] pat_char;
    logic       mdone;
    logic       busy;
    logic       finish;
    logic       len_ovf;

    logic mdone_auto  = 1'b0;
    logic mdone_force = 1'b0;
    assign mdone = mdone_auto | mdone_force;

    typedef struct {
        int           pno;
        int           len;
        logic [255:0] ch;
    } exp_t;

    logic [7:0]  rom [128];
    exp_t        exp_q [$];
    exp_t        cur_e;
    logic        exp_ovf;
    int          n_tests = 0;
    int          n_fail = 0;
    int          mdone_cnt = 0;
    bit          chk_en = 1'b0;
    int          max_addr = 0;
    int          obs_cnt = 0;
    int          obs_no [16];
    int          obs_len [16];
    logic [23:0] obs_ch [16];
    logic        prev_mstart = 1'b0;

    sme_pattern_sched dut (
        .clk              (clk),
        .reset            (reset),
        .go               (go),
        .case_insensitive (case_insensitive),
        .P_addr           (P_addr),
        .P_data           (P_data),
        .mstart           (mstart),
        .mpat_len         (mpat_len),
        .pattern_no       (pattern_no),
        .pat_idx          (pat_idx),
        .pat_char         (pat_char),
        .mdone            (mdone),
        .busy             (busy),
        .finish           (finish),
        .len_ovf          (len_ovf)
    );

    always #50 clk = ~clk;

    // Synchronous pattern ROM
    always @(posedge clk) P_data <= rom[P_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    endtask

    task automatic put_str(input int base, input string s);
        for (int i = 0; i < s.len(); i++) rom[base + i] = s[i];
    endtask

    // Reference: walk the table byte by byte and list every pattern that must be started
    task automatic build_expect(input logic ci);
        exp_t e;
        int   pno;
        int   len;
        logic [7:0] b;
        exp_q.delete();
        exp_ovf = 1'b0;
        pno = 0;
        len = 0;
        e.ch = '0;
        for (int a = 0; a < 128; a++) begin
            b = rom[a];
            if (b == 8'h00) break;
            if (b == 8'h0A) begin
                if (len > 0) begin
                    e.pno = pno; e.len = len; exp_q.push_back(e);
                end
                if (pno == 15) break;
                pno++;
                len = 0;
            end else begin
                if (len < 32) begin
                    e.ch[8*len +: 8] = (ci && b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
                    len++;
                end else begin
                    exp_ovf = 1'b1;
                end
                if (a == 127) begin
                    e.pno = pno; e.len = len; exp_q.push_back(e);
                end
            end
        end
    endtask

    // Matcher model and per-start comparison against the reference list
    always @(negedge clk) begin
        mdone_auto = 1'b0;
        if (!reset) begin
            mdone_cnt   = 0;
            prev_mstart = 1'b0;
        end else if (chk_en) begin
            if (mdone_cnt != 0) begin
                mdone_cnt--;
                if (mdone_cnt == 0) mdone_auto = 1'b1;
            end
            if (int'(P_addr) > max_addr) max_addr = int'(P_addr);
            if (mstart) begin
                chk("mstart_single_cycle", prev_mstart, 1'b0);
                chk("mstart_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur_e = exp_q.pop_front();
                    chk("pattern_no", pattern_no, cur_e.pno);
                    chk("mpat_len", mpat_len, cur_e.len);
                    for (int i = 0; i < cur_e.len && i < 32; i++) begin
                        pat_idx = 5'(i);
                        #1;
                        chk($sformatf("pat_char[%0d]", i), pat_char, cur_e.ch[8*i +: 8]);
                        if (i < 3 && obs_cnt < 16) obs_ch[obs_cnt][8*i +: 8] = pat_char;
                    end
                    if (obs_cnt < 16) begin
                        obs_no[obs_cnt]  = int'(pattern_no);
                        obs_len[obs_cnt] = int'(mpat_len);
                    end
                    obs_cnt++;
                end
                mdone_cnt = 3;
            end
            prev_mstart = mstart;
        end
    end

    task automatic run_pass(input logic ci, input int budget);
        int cyc;
        int n_exp;
        build_expect(ci);
        n_exp = exp_q.size();
        obs_cnt = 0;
        max_addr = 0;
        for (int i = 0; i < 16; i++) obs_ch[i] = 24'h0;
        @(negedge clk);
        go = 1'b1;
        case_insensitive = ci;
        @(negedge clk);
        go = 1'b0;
        case_insensitive = ~ci;
        chk("paddr_after_go", P_addr, 7'd0);
        chk("busy_after_go", busy, 1'b1);
        chk("finish_cleared", finish, 1'b0);
        cyc = 0;
        while (finish !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("finish_reached", finish, 1'b1);
        chk("busy_at_finish", busy, 1'b0);
        chk("len_ovf", len_ovf, exp_ovf);
        chk("mstart_count", obs_cnt, n_exp);
        chk("unstarted_patterns", exp_q.size(), 0);
    endtask

    task automatic load_rom1();
        clear_rom();
        put_str(0, "abc\nXyZ\n");
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        go = 1'b0;
        case_insensitive = 1'b0;
        pat_idx = 5'd0;
        clear_rom();
        repeat (2) @(negedge clk);
        chk("rst_paddr", P_addr, 7'd0);
        chk("rst_mstart", mstart, 1'b0);
        chk("rst_mpat_len", mpat_len, 6'd0);
        chk("rst_pattern_no", pattern_no, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_len_ovf", len_ovf, 1'b0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Two patterns, no folding
        load_rom1();
        run_pass(1'b0, 400);
        chk("t1_count", obs_cnt, 2);
        chk("t1_no0", obs_no[0], 0);
        chk("t1_no1", obs_no[1], 1);
        chk("t1_len0", obs_len[0], 3);
        chk("t1_len1", obs_len[1], 3);
        chk("t1_chars0", obs_ch[0], 24'h636261);
        chk("t1_chars1", obs_ch[1], 24'h5A7958);
        chk("t1_ovf", len_ovf, 1'b0);

        // Same table, folded
        run_pass(1'b1, 400);
        chk("t2_chars1", obs_ch[1], 24'h7A7978);

        // Overlong pattern truncated
        clear_rom();
        for (int i = 0; i < 40; i++) rom[i] = 8'h61;
        rom[40] = 8'h0A;
        run_pass(1'b0, 600);
        chk("t3_count", obs_cnt, 1);
        chk("t3_len", obs_len[0], 32);
        chk("t3_ovf", len_ovf, 1'b1);

        // Leading empty pattern consumes a number
        clear_rom();
        put_str(0, "\nab\n");
        run_pass(1'b0, 400);
        chk("t4_count", obs_cnt, 1);
        chk("t4_no", obs_no[0], 1);
        chk("t4_len", obs_len[0], 2);

        // Seventeen patterns: only sixteen are served
        clear_rom();
        for (int i = 0; i < 17; i++) put_str(2*i, "q\n");
        run_pass(1'b0, 2000);
        chk("t5_count", obs_cnt, 16);
        chk("t5_no15", obs_no[15], 15);
        chk("t5_len15", obs_len[15], 1);
        chk("t5_char15", obs_ch[15][7:0], 8'h71);
        chk("t5_max_paddr_ok", max_addr <= 33, 1'b1);

        // Reset while waiting for the matcher
        load_rom1();
        build_expect(1'b0);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 0;
        while (mstart !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_mstart_seen", mstart, 1'b1);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_paddr", P_addr, 7'd0);
        chk("t6_mstart", mstart, 1'b0);
        chk("t6_mpat_len", mpat_len, 6'd0);
        chk("t6_pattern_no", pattern_no, 4'd0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_finish", finish, 1'b0);
        chk("t6_len_ovf", len_ovf, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_idle_busy", busy, 1'b0);

        // Spurious mdone in IDLE
        mdone_force = 1'b1;
        repeat (2) @(negedge clk);
        mdone_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_busy", busy, 1'b0);
        chk("t7_finish", finish, 1'b0);
        chk("t7_pattern_no", pattern_no, 4'd0);
        chk("t7_paddr", P_addr, 7'd0);

        // Fresh pass after the abort
        load_rom1();
        run_pass(1'b0, 400);
        chk("t8_count", obs_cnt, 2);
        chk("t8_no0", obs_no[0], 0);
        chk("t8_chars0", obs_ch[0], 24'h636261);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sme_pattern_sched.md
Name: sme_pattern_sched

Overview:
- Controller in front of the string-matching datapath.
- Walks the 128x8 pattern ROM and splits the pattern table into individual patterns.
- Loads each pattern, case-folded when requested, into a local buffer, then hands it to the text-scan matcher with a start/done handshake, one pattern at a time.
- Numbers patterns 0..15 and raises finish when the table is exhausted.

Parameters:
- MAX_LEN, 32, pattern buffer depth in characters; longer patterns are truncated.
- TERM_CHAR, 8'h0A, pattern terminator byte.
- END_CHAR, 8'h00, end-of-table byte.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start a table pass; sampled only in IDLE or FINISH.
- case_insensitive  in  1  fold A-Z to a-z while loading; sampled with go and held for the pass.
- P_addr  out  7  pattern ROM address; the ROM is synchronous, so data returns on P_data one cycle later.
- P_data  in  8  pattern ROM read data.
- mstart  out  1  one-cycle pulse: buffer, mpat_len and pattern_no are valid.
- mpat_len  out  6  current pattern length, 1..MAX_LEN.
- pattern_no  out  4  index of the current pattern.
- pat_idx  in  5  matcher read index into the pattern buffer.
- pat_char  out  8  combinational buffer[pat_idx]; value beyond mpat_len is don't-care.
- mdone  in  1  matcher finished the current pattern.
- busy  out  1  high in every state except IDLE and FINISH.
- finish  out  1  level; all patterns processed.
- len_ovf  out  1  sticky per pass; some pattern exceeded MAX_LEN.

Behaviour:
- Reset, asynchronous and active-low: state IDLE.
  - P_addr, mstart, mpat_len, pattern_no, busy, finish and len_ovf are all 0.
  - The buffer contents are not reset.
- States: IDLE, PRIME, LOAD, START, WAIT_DONE, FINISH.
- IDLE or FINISH, go=1:
  - Go to PRIME; addr=0, pattern_no=0, len=0.
  - Clear finish and len_ovf; latch case_insensitive.
  - go in any other state is ignored.
- PRIME: drive P_addr=addr, addr+1, go to LOAD. This is the one-cycle ROM prime.
- LOAD: consume P_data (the byte at addr-1) and present the next address in the same cycle, giving one byte per cycle.
  - Ordinary byte:
    - If len<MAX_LEN, store it (folded if 8'h41..8'h5A and case fold is latched: +8'h20) and len+1.
    - Otherwise discard it and set len_ovf.
  - TERM_CHAR:
    - If len>0, go to START. The extra prefetched address is discarded; addr is rewound by 1.
    - If len==0 (empty pattern), pattern_no+1 with no start and stay in LOAD. If pattern_no was 15, go to FINISH.
  - END_CHAR: go to FINISH. A partial pattern with len>0 is dropped.
  - Byte at address 127 consumed without TERM or END: treat it as if END followed.
    - Commit a partial pattern with len>0 via START; after its mdone, go to FINISH.
    - The address never wraps to 0.
- START: mstart=1 for exactly one cycle; go to WAIT_DONE.
  - mpat_len=len, pattern_no and the buffer are frozen until mdone is accepted.
- WAIT_DONE, mdone=1:
  - If pattern_no==15 or the end condition is pending, go to FINISH.
  - Else pattern_no+1, len=0, go to PRIME at the saved addr.
- mdone outside WAIT_DONE is ignored, including mdone coincident with mstart.
- FINISH: finish=1 and busy=0; hold until go or reset. pattern_no keeps its last value.
- Reset mid-pass aborts immediately to IDLE values. No mstart is issued after reset deasserts until a new go.
- Latency:
  - go sampled → P_addr=0 presented next cycle.
  - First byte consumed 2 cycles after go.
  - Terminator consumed → mstart the next cycle.
  - mdone → next P_addr the following cycle.

Decomposition:
- Package sme_pkg holds:
  - the state enum;
  - TERM_CHAR and END_CHAR constants;
  - a to_lower function;
  - the PAT_ROM_AW=7 and PAT_NO_W=4 widths.
- One natural sub-module: sme_pat_buf, the MAX_LEN x 8 register file.
  - Write port: wr_en, wr_idx, wr_data.
  - Asynchronous read port: pat_idx → pat_char.

Test Plan:
- ROM "abc\n" "XyZ\n" 00, case_insensitive=0, matcher mdone 3 cycles after each mstart:
  - mstart twice; pattern_no 0 then 1; mpat_len 3 then 3.
  - pat_char[0..2] = 61,62,63 then 58,79,5A.
  - finish high; len_ovf=0.
- Same ROM, case_insensitive=1 → second pattern reads 78,79,7A.
- ROM of 40 'a' then "\n" 00 → mpat_len=32, len_ovf=1, exactly one mstart, then finish.
- ROM "\n" "ab\n" 00 → a single mstart with pattern_no=1, mpat_len=2.
- ROM of 17 patterns "q\n" → 16 mstarts, pattern_no 0..15; finish after the 16th mdone; no P_addr reads past byte 33.
- Reset pulled low during WAIT_DONE → all outputs 0 immediately.
- Spurious mdone in IDLE → no effect.
- New go → the pass restarts at P_addr=0 with pattern_no=0.
